// File: rtl/adder_acc_pkg.sv
// Shared types and helpers for the adder result accumulator.
package adder_acc_pkg;

    typedef enum logic {ACC, HOLD} acc_state_t;

    localparam int unsigned SAMPLE_W  = 5;
    localparam int unsigned SAT_MAX_W = 32;
    localparam int unsigned SAT_RES_W = SAT_MAX_W + 1;

    // Saturating add of one sample onto an acc_w-bit accumulator; returns {ovf, result}.
    function automatic logic [SAT_RES_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAMPLE_W-1:0]  sample,
        input int unsigned          acc_w
    );
        logic [SAT_RES_W-1:0] sum_w;
        logic [SAT_RES_W-1:0] max_w;
        sum_w = {1'b0, acc} + SAT_RES_W'(sample);
        max_w = (SAT_RES_W'(1) << acc_w) - SAT_RES_W'(1);
        if (sum_w > max_w) begin
            sat_add = {1'b1, max_w[SAT_MAX_W-1:0]};
        end else begin
            sat_add = {1'b0, sum_w[SAT_MAX_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/adder_sat_add.sv
// Combinational saturating adder: acc + 5-bit sample, clamped to all-ones.
module adder_sat_add
    import adder_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 8
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [ACC_W-1:0]    result_c,
    output logic                ovf_c
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] sum_w;

    // One extra bit catches any sum above the ACC_W-bit maximum.
    always_comb begin
        sum_w    = {1'b0, acc} + SUM_W'(sample);
        ovf_c    = sum_w[ACC_W];
        result_c = ovf_c ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates N_SAMPLES adder results {carry, sum} into a saturating frame total
// and hands each finished frame downstream over a valid/ready port.
module adder_sum_accumulator
    import adder_acc_pkg::*;
#(
    parameter  int unsigned N_SAMPLES = 4,
    parameter  int unsigned ACC_W     = 8,
    localparam int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] total,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    acc_state_t       state;
    acc_state_t       state_nxt;
    logic [ACC_W-1:0] total_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             overflow_nxt;
    logic [ACC_W-1:0] sat_result_c;
    logic             sat_ovf_c;

    adder_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc      (total),
        .sample   ({carry, sum}),
        .result_c (sat_result_c),
        .ovf_c    (sat_ovf_c)
    );

    // Handshake flags come straight from state: no path from in_valid/out_ready.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        total_nxt    = total;
        count_nxt    = count;
        overflow_nxt = overflow;
        case (state)
            ACC: begin
                if (in_valid) begin
                    total_nxt    = sat_result_c;
                    overflow_nxt = overflow | sat_ovf_c;
                    count_nxt    = count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    total_nxt    = '0;
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                    state_nxt    = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            total    <= total_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Scoreboard bench for adder_sum_accumulator across three parameter sets.
module tb_adder_sum_accumulator;

    typedef struct {
        int total;
        int count;
        bit ovf;
    } exp_t;

    logic clk;
    logic rst;

    // Instance A: N=4, ACC_W=8
    logic       a_in_valid, a_in_ready, a_carry, a_out_valid, a_out_ready, a_overflow;
    logic [3:0] a_sum;
    logic [7:0] a_total;
    logic [2:0] a_count;
    // Instance B: N=4, ACC_W=6
    logic       b_in_valid, b_in_ready, b_carry, b_out_valid, b_out_ready, b_overflow;
    logic [3:0] b_sum;
    logic [5:0] b_total;
    logic [2:0] b_count;
    // Instance C: N=1, ACC_W=8
    logic       c_in_valid, c_in_ready, c_carry, c_out_valid, c_out_ready, c_overflow;
    logic [3:0] c_sum;
    logic [7:0] c_total;
    logic [0:0] c_count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    adder_sum_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sum(a_sum), .carry(a_carry), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .total(a_total), .count(a_count), .overflow(a_overflow)
    );

    adder_sum_accumulator #(.N_SAMPLES(4), .ACC_W(6)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sum(b_sum), .carry(b_carry), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .total(b_total), .count(b_count), .overflow(b_overflow)
    );

    adder_sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .sum(c_sum), .carry(c_carry), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .total(c_total), .count(c_count), .overflow(c_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference saturating accumulate, independent of the RTL helpers.
    function automatic int model_add(input int acc, input int smp, input int w, inout bit ovf);
        int maxv;
        maxv = (1 << w) - 1;
        if (acc + smp > maxv) begin
            ovf = 1'b1;
            return maxv;
        end
        return acc + smp;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({a_total, a_count, a_overflow, a_out_valid, a_in_ready} !== {8'd0, 3'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_a: total=%0d count=%0d ovf=%0b ov=%0b ir=%0b, want 0 0 0 0 1",
                     a_total, a_count, a_overflow, a_out_valid, a_in_ready);
        else n_pass++;
        n_checks++;
        if ({b_total, b_count, b_overflow, b_out_valid, b_in_ready} !== {6'd0, 3'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_b: total=%0d count=%0d ovf=%0b ov=%0b ir=%0b, want 0 0 0 0 1",
                     b_total, b_count, b_overflow, b_out_valid, b_in_ready);
        else n_pass++;
        n_checks++;
        if ({c_total, c_count, c_overflow, c_out_valid, c_in_ready} !== {8'd0, 1'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_c: total=%0d count=%0d ovf=%0b ov=%0b ir=%0b, want 0 0 0 0 1",
                     c_total, c_count, c_overflow, c_out_valid, c_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [4:0] smp[4];
        int   acc;
        bit   ovf;
        exp_t e;
        smp = '{5'd5, 5'd7, 5'd3, 5'd16};
        acc = 0;
        ovf = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {a_carry, a_sum} = smp[i];
            a_in_valid = 1'b1;
            acc = model_add(acc, int'(smp[i]), 8, ovf);
            step();
        end
        exp_q.push_back('{acc, 4, ovf});
        a_in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0)
            $display("FAIL basic_latency: out_valid=%0b in_ready=%0b, want 1 0", a_out_valid, a_in_ready);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (a_total !== 8'(e.total) || a_count !== 3'(e.count) || a_overflow !== e.ovf)
            $display("FAIL basic_frame: total=%0d count=%0d ovf=%0b, want %0d %0d %0b",
                     a_total, a_count, a_overflow, e.total, e.count, e.ovf);
        else n_pass++;
        step();
        n_checks++;
        if (a_total !== 8'd0 || a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
            $display("FAIL basic_clear: total=%0d count=%0d ov=%0b ir=%0b, want 0 0 0 1",
                     a_total, a_count, a_out_valid, a_in_ready);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int   acc;
        bit   ovf;
        exp_t e;
        logic [4:0] smp[4];
        smp = '{5'd31, 5'd31, 5'd31, 5'd0};
        acc = 0;
        ovf = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {b_carry, b_sum} = smp[i];
            b_in_valid = 1'b1;
            acc = model_add(acc, int'(smp[i]), 6, ovf);
            step();
        end
        exp_q.push_back('{acc, 4, ovf});
        b_in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (b_out_valid !== 1'b1 || b_total !== 6'(e.total) || b_count !== 3'(e.count) || b_overflow !== e.ovf)
            $display("FAIL sat_frame: ov=%0b total=%0d count=%0d ovf=%0b, want 1 %0d %0d %0b",
                     b_out_valid, b_total, b_count, b_overflow, e.total, e.count, e.ovf);
        else n_pass++;
        step();
        {b_carry, b_sum} = 5'd1;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        n_checks++;
        if (b_overflow !== 1'b0 || b_total !== 6'd1 || b_count !== 3'd1)
            $display("FAIL sat_next_frame: ovf=%0b total=%0d count=%0d, want 0 1 1",
                     b_overflow, b_total, b_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   bad;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        {a_carry, a_sum} = 5'd1;
        for (int i = 0; i < 4; i++) step();
        exp_q.push_back('{4, 4, 1'b0});
        {a_carry, a_sum} = 5'd3;
        e = exp_q.pop_front();
        n_checks++;
        if (a_out_valid !== 1'b1 || a_total !== 8'(e.total) || a_count !== 3'(e.count) || a_overflow !== e.ovf)
            $display("FAIL bp_frame: ov=%0b total=%0d count=%0d ovf=%0b, want 1 %0d %0d %0b",
                     a_out_valid, a_total, a_count, a_overflow, e.total, e.count, e.ovf);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_total !== 8'd4 || a_count !== 3'd4) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles, want 0", bad);
        else n_pass++;
        a_out_ready = 1'b1;
        step();
        step();
        a_in_valid = 1'b0;
        n_checks++;
        if (a_count !== 3'd1 || a_total !== 8'd3 || a_out_valid !== 1'b0)
            $display("FAIL bp_pending: count=%0d total=%0d ov=%0b, want 1 3 0", a_count, a_total, a_out_valid);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_gaps();
        int   acc;
        int   cnt;
        int   bad;
        bit   ovf;
        exp_t e;
        acc = 0;
        cnt = 0;
        bad = 0;
        ovf = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_in_valid = (i % 2 == 0);
            if (a_in_valid) begin
                {a_carry, a_sum} = 5'(i + 2);
                acc = model_add(acc, i + 2, 8, ovf);
                cnt++;
            end else begin
                {a_carry, a_sum} = 5'd31;
            end
            step();
            if (cnt < 4 && (a_count !== 3'(cnt) || a_total !== 8'(acc))) bad++;
        end
        exp_q.push_back('{acc, cnt, ovf});
        a_in_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL gaps_progress: %0d wrong cycles, want 0", bad);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (a_out_valid !== 1'b1 || a_total !== 8'(e.total) || a_count !== 3'(e.count) || a_overflow !== e.ovf)
            $display("FAIL gaps_frame: ov=%0b total=%0d count=%0d ovf=%0b, want 1 %0d %0d %0b",
                     a_out_valid, a_total, a_count, a_overflow, e.total, e.count, e.ovf);
        else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        exp_t e;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        {a_carry, a_sum} = 5'd2;
        step();
        step();
        a_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_total !== 8'd0 || a_count !== 3'd0 || a_overflow !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
            $display("FAIL arst_immediate: total=%0d count=%0d ovf=%0b ov=%0b ir=%0b, want 0 0 0 0 1",
                     a_total, a_count, a_overflow, a_out_valid, a_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        exp_q.push_back('{8, 4, 1'b0});
        a_in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (a_out_valid !== 1'b1 || a_total !== 8'(e.total) || a_count !== 3'(e.count) || a_overflow !== e.ovf)
            $display("FAIL arst_next_frame: ov=%0b total=%0d count=%0d ovf=%0b, want 1 %0d %0d %0b",
                     a_out_valid, a_total, a_count, a_overflow, e.total, e.count, e.ovf);
        else n_pass++;
        step();
    endtask

    task automatic test_single_sample();
        exp_t e;
        logic [3:0] rdy;
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        {c_carry, c_sum} = 5'd9;
        exp_q.push_back('{9, 1, 1'b0});
        rdy[3] = c_in_ready;
        step();
        rdy[2] = c_in_ready;
        e = exp_q.pop_front();
        n_checks++;
        if (c_out_valid !== 1'b1 || c_total !== 8'(e.total) || c_count !== 1'(e.count))
            $display("FAIL n1_frame0: ov=%0b total=%0d count=%0d, want 1 %0d %0d",
                     c_out_valid, c_total, c_count, e.total, e.count);
        else n_pass++;
        {c_carry, c_sum} = 5'd17;
        exp_q.push_back('{17, 1, 1'b0});
        step();
        rdy[1] = c_in_ready;
        step();
        rdy[0] = c_in_ready;
        c_in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (c_out_valid !== 1'b1 || c_total !== 8'(e.total) || c_count !== 1'(e.count))
            $display("FAIL n1_frame1: ov=%0b total=%0d count=%0d, want 1 %0d %0d",
                     c_out_valid, c_total, c_count, e.total, e.count);
        else n_pass++;
        n_checks++;
        if (rdy !== 4'b1010) $display("FAIL n1_ready_pattern: got %b, want 1010", rdy);
        else n_pass++;
        step();
    endtask

    initial begin
        rst = 1'b1;
        {a_in_valid, a_carry, a_sum, a_out_ready} = '0;
        {b_in_valid, b_carry, b_sum, b_out_ready} = '0;
        {c_in_valid, c_carry, c_sum, c_out_ready} = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_gaps();
        test_async_reset();
        test_single_sample();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
